// File: rtl/ines_loader_if.sv
// ines_loader_if: byte-stream handshake plus ROM programming write port.
//   byte_valid / byte_data : image byte offered by the source
//   byte_ready             : loader takes the byte this cycle
//   wr_en / wr_addr / wr_data : registered ROM write strobe, byte address, data
// Modports: master = source/ROM side (testbench), slave = loader.
interface ines_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/ines_loader.sv
// ines_loader: streams an NROM iNES image into the cartridge ROM, validating
// the 16-byte header on the fly, and holds the CPU in reset until the whole
// image is written.
// Ports:
//   cpu_clk, rst : clock, asynchronous active-high reset
//   start        : single-cycle pulse, begins/restarts a load (IDLE/DONE/ERROR)
//   bus          : byte stream in + ROM write port out (ines_loader_if.slave)
//   busy         : loading (HEADER or PAYLOAD)
//   done         : valid image fully written
//   error        : load aborted; err_code = 0 magic, 1 banks, 2 mapper/trainer,
//                  3 timeout
//   cpu_hold     : CPU reset hold, low only once the image is complete
module ines_loader #(
    parameter int ROM_BYTES      = 'h6010,
    parameter int PRG_BANKS      = 1,
    parameter int CHR_BANKS      = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         cpu_clk,
    input  logic         rst,
    input  logic         start,
    ines_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [1:0]   err_code,
    output logic         cpu_hold
);
    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_PAYLOAD, S_DONE, S_ERROR
    } state_t;

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);
    // The limit is hit on the idle cycle that would make the count reach
    // TIMEOUT_CYCLES, so a transfer on that same cycle can still win.
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [14:0]   OFF_LAST = 15'(ROM_BYTES - 1);

    state_t        state_q, state_d;
    logic [14:0]   off_q, off_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    code_q, code_d;
    logic          wr_en_q, wr_en_d;
    logic [14:0]   wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;

    logic          xfer;
    logic          tmo_hit;
    logic          chk_fail;
    logic [1:0]    chk_code;

    assign xfer    = bus.byte_valid & busy;
    assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);

    // Header rule for the byte currently offered; only meaningful in HEADER,
    // where off_q is 0..15.
    always_comb begin
        chk_fail = 1'b0;
        chk_code = 2'd0;
        if (state_q == S_HEADER) begin
            case (off_q[3:0])
                4'd0: chk_fail = (bus.byte_data != 8'h4E);
                4'd1: chk_fail = (bus.byte_data != 8'h45);
                4'd2: chk_fail = (bus.byte_data != 8'h53);
                4'd3: chk_fail = (bus.byte_data != 8'h1A);
                4'd4: begin
                    chk_fail = (bus.byte_data != 8'(PRG_BANKS));
                    chk_code = 2'd1;
                end
                4'd5: begin
                    chk_fail = (bus.byte_data != 8'(CHR_BANKS));
                    chk_code = 2'd1;
                end
                4'd6: begin
                    chk_fail = (|bus.byte_data[7:4]) | bus.byte_data[2];
                    chk_code = 2'd2;
                end
                4'd7: begin
                    chk_fail = |bus.byte_data[7:4];
                    chk_code = 2'd2;
                end
                default: chk_fail = 1'b0;
            endcase
        end
    end

    // FSM: state register
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HEADER;
            end
            S_HEADER: begin
                if (xfer) begin
                    if (chk_fail) begin
                        state_d = S_ERROR;
                        code_d  = chk_code;
                    end else if (off_q == 15'd15) begin
                        state_d = S_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                    code_d  = 2'd3;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    if (off_q == OFF_LAST) state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_ERROR;
                    code_d  = 2'd3;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_HEADER;
                    code_d  = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (state_q == S_HEADER) || (state_q == S_PAYLOAD);
        done     = (state_q == S_DONE);
        error    = (state_q == S_ERROR);
        cpu_hold = (state_q != S_DONE);
        err_code = code_q;
    end

    // Offset / idle counters and the registered ROM write
    always_comb begin
        off_d     = off_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_d == S_HEADER && state_q != S_HEADER) begin
            off_d = '0;
            tmo_d = '0;
        end else if (xfer) begin
            tmo_d = '0;
            off_d = off_q + 15'd1;
            // A byte that breaks a header rule is accepted but never written.
            if (!chk_fail) begin
                wr_en_d   = 1'b1;
                wr_addr_d = off_q;
                wr_data_d = bus.byte_data;
            end
        end else if (busy) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            off_q     <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            off_q     <= off_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.byte_ready = busy;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
endmodule
